// File: rtl/down_counter_ld.sv
// down_counter_ld: loadable, prescaled down-counter with a terminal-count pulse.
// LOAD captures a start value and a reload value. The count then steps down
// once every PRESCALE enabled clocks. On reaching zero the block pulses TC and
// either stops (one-shot) or reloads the captured value (auto-reload).
module down_counter_ld #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             CLK,
    input  logic             RSTdash,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             AUTO,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qdash,
    output logic             ZERO,
    output logic             TC,
    output logic             BUSY
);

    // The prescaler needs at least one bit, even when PRESCALE is 1.
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0]   PS_LAST = PSW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PSW-1:0]   ps_q, ps_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             a_q, a_d;
    logic             tc_q, tc_d;

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) begin
            state_q <= IDLE;
            ps_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            a_q     <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            q_q     <= q_d;
            r_q     <= r_d;
            a_q     <= a_d;
            tc_q    <= tc_d;
        end
    end

    // Next state: LOAD beats everything; otherwise count only in RUN with EN high.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        q_d     = q_q;
        r_d     = r_q;
        a_d     = a_q;
        tc_d    = 1'b0;

        if (LOAD) begin
            q_d     = D;
            r_d     = D;
            a_d     = AUTO;
            ps_d    = '0;
            // Loading zero leaves nothing to count, so no TC is produced.
            state_d = (D != '0) ? RUN : IDLE;
        end else if (state_q == RUN && EN) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (q_q > ONE) begin
                    q_d = q_q - ONE;
                end else begin
                    // Q is 1 here: RUN never holds a zero count.
                    tc_d = 1'b1;
                    if (a_q) begin
                        // Jump straight to the reload value, skipping 0.
                        q_d = r_q;
                    end else begin
                        q_d     = '0;
                        state_d = IDLE;
                    end
                end
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    assign Q     = q_q;
    assign Qdash = ~q_q;
    assign ZERO  = (q_q == '0);
    assign TC    = tc_q;
    assign BUSY  = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_ld.sv
// Directed bench for down_counter_ld: one instance with PRESCALE=4 and one with
// PRESCALE=1, sharing clock and reset, each with its own control inputs.
module tb_down_counter_ld;

    logic       clk;
    logic       rst_n;

    logic       a_load, a_auto, a_en;
    logic [7:0] a_d;
    logic [7:0] a_q, a_qdash;
    logic       a_zero, a_tc, a_busy;

    logic       b_load, b_auto, b_en;
    logic [7:0] b_d;
    logic [7:0] b_q, b_qdash;
    logic       b_zero, b_tc, b_busy;

    int checks;
    int errors;

    down_counter_ld #(.WIDTH(8), .PRESCALE(4)) u_ps4 (
        .CLK(clk), .RSTdash(rst_n), .LOAD(a_load), .D(a_d), .AUTO(a_auto),
        .EN(a_en), .Q(a_q), .Qdash(a_qdash), .ZERO(a_zero), .TC(a_tc),
        .BUSY(a_busy)
    );

    down_counter_ld #(.WIDTH(8), .PRESCALE(1)) u_ps1 (
        .CLK(clk), .RSTdash(rst_n), .LOAD(b_load), .D(b_d), .AUTO(b_auto),
        .EN(b_en), .Q(b_q), .Qdash(b_qdash), .ZERO(b_zero), .TC(b_tc),
        .BUSY(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [7:0] eq, input logic etc, input logic ebusy);
        check({tag, ".Q"}, {24'd0, a_q}, {24'd0, eq});
        check({tag, ".Qdash"}, {24'd0, a_qdash}, {24'd0, ~eq});
        check({tag, ".ZERO"}, {31'd0, a_zero}, {31'd0, (eq == 8'd0)});
        check({tag, ".TC"}, {31'd0, a_tc}, {31'd0, etc});
        check({tag, ".BUSY"}, {31'd0, a_busy}, {31'd0, ebusy});
    endtask

    task automatic check_b(input string tag, input logic [7:0] eq, input logic etc, input logic ebusy);
        check({tag, ".Q"}, {24'd0, b_q}, {24'd0, eq});
        check({tag, ".Qdash"}, {24'd0, b_qdash}, {24'd0, ~eq});
        check({tag, ".ZERO"}, {31'd0, b_zero}, {31'd0, (eq == 8'd0)});
        check({tag, ".TC"}, {31'd0, b_tc}, {31'd0, etc});
        check({tag, ".BUSY"}, {31'd0, b_busy}, {31'd0, ebusy});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        a_load = 0; a_auto = 0; a_en = 0; a_d = 8'd0;
        b_load = 0; b_auto = 0; b_en = 0; b_d = 8'd0;
        rst_n = 1'b1;

        // Power-on reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check_a("por_a", 8'd0, 1'b0, 1'b0);
        check_b("por_b", 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        a_en = 1'b1; b_en = 1'b1;
        tick();
        tick();
        check_a("post_por_idle_a", 8'd0, 1'b0, 1'b0);
        $display("txn reset: checks=%0d errors=%0d", checks, errors);

        // One-shot, PRESCALE=4, D=3: Q=3,2,1,0 at edges 0,4,8,12.
        a_load = 1; a_d = 8'd3; a_auto = 0; a_en = 1;
        tick();
        a_load = 0;
        check_a("os_e0", 8'd3, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 4)       check_a("os_a", 8'd3, 1'b0, 1'b1);
            else if (k < 8)  check_a("os_b", 8'd2, 1'b0, 1'b1);
            else if (k < 12) check_a("os_c", 8'd1, 1'b0, 1'b1);
            else             check_a("os_e12", 8'd0, 1'b1, 1'b0);
        end
        tick();
        check_a("os_e13", 8'd0, 1'b0, 1'b0);
        $display("txn one-shot D=3: checks=%0d errors=%0d", checks, errors);

        // Auto-reload, PRESCALE=1, D=2: Q=2,1,2,1,... with TC after every even edge.
        b_load = 1; b_d = 8'd2; b_auto = 1; b_en = 1;
        tick();
        b_load = 0;
        check_b("ar_e0", 8'd2, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k % 2 == 1) check_b("ar_odd", 8'd1, 1'b0, 1'b1);
            else            check_b("ar_even", 8'd2, 1'b1, 1'b1);
        end
        // Stop it with a zero load: IDLE, no TC.
        b_load = 1; b_d = 8'd0; b_auto = 0;
        tick();
        b_load = 0;
        check_b("ar_stop", 8'd0, 1'b0, 1'b0);
        $display("txn auto-reload D=2: checks=%0d errors=%0d", checks, errors);

        // Enable gap, PRESCALE=4, D=2, EN low for edges 3..5.
        a_load = 1; a_d = 8'd2; a_auto = 0; a_en = 1;
        tick();
        a_load = 0;
        check_a("gap_e0", 8'd2, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            a_en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            tick();
            if (k < 7)       check_a("gap_q2", 8'd2, 1'b0, 1'b1);
            else if (k < 11) check_a("gap_q1", 8'd1, 1'b0, 1'b1);
            else if (k == 11) check_a("gap_e11", 8'd0, 1'b1, 1'b0);
            else             check_a("gap_e12", 8'd0, 1'b0, 1'b0);
        end
        $display("txn enable-gap D=2: checks=%0d errors=%0d", checks, errors);

        // Load collision: LOAD D=9 on the edge that would take Q 1->0.
        a_load = 1; a_d = 8'd1; a_auto = 0; a_en = 1;
        tick();
        a_load = 0;
        check_a("col_e0", 8'd1, 1'b0, 1'b1);
        tick(); tick(); tick();
        a_load = 1; a_d = 8'd9;
        tick();
        a_load = 0;
        check_a("col_load9", 8'd9, 1'b0, 1'b1);
        tick();
        tick();
        // LOAD D=0 while running: IDLE with no TC.
        a_load = 1; a_d = 8'd0;
        tick();
        a_load = 0;
        check_a("col_load0", 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        check_a("col_idle_hold", 8'd0, 1'b0, 1'b0);
        $display("txn load-collision: checks=%0d errors=%0d", checks, errors);

        // Full-range one-shot, PRESCALE=1, D=8'hFF: TC after edge 255.
        b_load = 1; b_d = 8'hFF; b_auto = 0; b_en = 1;
        tick();
        b_load = 0;
        check_b("wide_e0", 8'hFF, 1'b0, 1'b1);
        for (int k = 1; k <= 255; k++) begin
            tick();
            check_b("wide", 8'(255 - k), (k == 255), (k != 255));
        end
        tick();
        check_b("wide_after", 8'd0, 1'b0, 1'b0);
        $display("txn wide D=FF: checks=%0d errors=%0d", checks, errors);

        // Asynchronous reset in the middle of a count with Q=5.
        a_load = 1; a_d = 8'd5; a_auto = 1; a_en = 1;
        tick();
        a_load = 0;
        tick(); tick();
        check_a("rst_pre", 8'd5, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_a("rst_async", 8'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check_a("rst_idle", 8'd0, 1'b0, 1'b0);
        a_load = 1; a_d = 8'd4;
        tick();
        a_load = 0;
        check_a("rst_reload", 8'd4, 1'b0, 1'b1);
        $display("txn mid-count reset: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
